// File: rtl/vrc_seg_if.sv
// rtl/vrc_seg_if.sv - control, segment-table write and gain-code bus of the VRC segment generator
interface vrc_seg_if #(
    parameter int AMP_W = 10,
    parameter int SEG_N = 4,
    parameter int LEN_W = 16,
    parameter int INC_W = 20
);
    localparam int SEG_AW = (SEG_N > 1) ? $clog2(SEG_N) : 1;

    logic              i_sync;
    logic              i_process;
    logic [AMP_W:0]    i_start_amp;
    logic [AMP_W-1:0]  i_amp_porch;
    logic              i_wr;
    logic [SEG_AW-1:0] i_wr_addr;
    logic [LEN_W-1:0]  i_wr_len;
    logic [INC_W-1:0]  i_wr_inc;
    logic [AMP_W-1:0]  o_amp_one;
    logic [AMP_W-1:0]  o_amp_two;
    logic [SEG_AW-1:0] o_seg;
    logic              o_done;

    modport master (
        output i_sync, i_process, i_start_amp, i_amp_porch,
        output i_wr, i_wr_addr, i_wr_len, i_wr_inc,
        input  o_amp_one, o_amp_two, o_seg, o_done
    );

    modport slave (
        input  i_sync, i_process, i_start_amp, i_amp_porch,
        input  i_wr, i_wr_addr, i_wr_len, i_wr_inc,
        output o_amp_one, o_amp_two, o_seg, o_done
    );
endinterface

// File: rtl/vrc_seg.sv
// rtl/vrc_seg.sv - multi-segment VRC/TVG gain-curve generator; VRC_SIGNED_INC_EN enables signed increments
module vrc_seg #(
    parameter int AMP_W    = 10,
    parameter int FRAC_W   = 13,
    parameter int SEG_N    = 4,
    parameter int LEN_W    = 16,
    parameter int INC_W    = 20,
    parameter int TWO_BASE = 128
) (
    input  logic     clk,
    input  logic     rst_n,
    vrc_seg_if.slave bus
);
    localparam int ACC_W  = AMP_W + 1 + FRAC_W;
    localparam int SEG_AW = (SEG_N > 1) ? $clog2(SEG_N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [LEN_W-1:0]  len_tab [SEG_N];
    logic [INC_W-1:0]  inc_tab [SEG_N];
    logic [1:0]        state;
    logic [SEG_AW-1:0] seg;
    logic [SEG_AW-1:0] seg_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cur_len;
    logic [INC_W-1:0]  cur_inc;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic              stepping;
    logic              advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEG_N; i++) begin
                len_tab[i] <= '0;
                inc_tab[i] <= '0;
            end
        end else if (bus.i_wr) begin
            len_tab[bus.i_wr_addr] <= bus.i_wr_len;
            inc_tab[bus.i_wr_addr] <= bus.i_wr_inc;
        end
    end

`ifdef VRC_SIGNED_INC_EN
    logic signed [ACC_W+1:0] sum_s;
    always_comb begin
        sum_s = $signed({2'b00, acc}) + $signed({{(ACC_W+2-INC_W){cur_inc[INC_W-1]}}, cur_inc});
        if (sum_s[ACC_W+1])
            acc_next = '0;
        else if (sum_s[ACC_W])
            acc_next = '1;
        else
            acc_next = sum_s[ACC_W-1:0];
    end
`else
    logic [ACC_W:0] sum_u;
    always_comb begin
        sum_u    = {1'b0, acc} + {{(ACC_W+1-INC_W){1'b0}}, cur_inc};
        acc_next = sum_u[ACC_W] ? '1 : sum_u[ACC_W-1:0];
    end
`endif

    // A zero-length segment is skipped in one clock whether or not i_process is high.
    assign seg_nxt  = seg + 1'b1;
    assign stepping = (state == ST_RUN) && bus.i_process && (cur_len != '0);
    assign advance  = (state == ST_RUN) &&
                      ((cur_len == '0) || (bus.i_process && (cnt == cur_len - 1'b1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            seg     <= '0;
            cnt     <= '0;
            cur_len <= '0;
            cur_inc <= '0;
        end else if (bus.i_sync) begin
            state   <= ST_RUN;
            acc     <= {bus.i_start_amp, {FRAC_W{1'b0}}};
            seg     <= '0;
            cnt     <= '0;
            cur_len <= len_tab[0];
            cur_inc <= inc_tab[0];
        end else begin
            case (state)
                ST_IDLE: acc <= {bus.i_start_amp, {FRAC_W{1'b0}}};
                ST_RUN: begin
                    if (stepping) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                    end
                    if (advance) begin
                        cnt <= '0;
                        if (seg == SEG_AW'(SEG_N - 1)) begin
                            state <= ST_HOLD;
                        end else begin
                            seg     <= seg_nxt;
                            cur_len <= len_tab[seg_nxt];
                            cur_inc <= inc_tab[seg_nxt];
                        end
                    end
                end
                ST_HOLD: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage two starts at TWO_BASE and only climbs once stage one has run out of range.
    logic [AMP_W:0]   amp;
    logic [AMP_W-1:0] one_raw;
    logic [AMP_W:0]   two_sum;
    logic [AMP_W-1:0] two_raw;
    logic [AMP_W-1:0] amp_one_q;
    logic [AMP_W-1:0] amp_two_q;

    always_comb begin
        amp     = acc[ACC_W-1:FRAC_W];
        one_raw = amp[AMP_W] ? '1 : amp[AMP_W-1:0];
        two_sum = (AMP_W+1)'(TWO_BASE) + {1'b0, (amp[AMP_W] ? amp[AMP_W-1:0] : {AMP_W{1'b0}})};
        two_raw = two_sum[AMP_W] ? '1 : two_sum[AMP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amp_one_q <= '0;
            amp_two_q <= '0;
        end else begin
            amp_one_q <= (one_raw > bus.i_amp_porch) ? one_raw : bus.i_amp_porch;
            amp_two_q <= (two_raw > bus.i_amp_porch) ? two_raw : bus.i_amp_porch;
        end
    end

    assign bus.o_amp_one = amp_one_q;
    assign bus.o_amp_two = amp_two_q;
    assign bus.o_seg     = seg;
    assign bus.o_done    = (state == ST_HOLD);
endmodule

// File: tb/tb_vrc_seg.sv
// tb/tb_vrc_seg.sv - directed self-checking bench for vrc_seg
module tb_vrc_seg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    vrc_seg_if bus ();
    vrc_seg dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

`ifdef VRC_SIGNED_INC_EN
    localparam logic [19:0] SAT_INC   = 20'h7FFFF;
    localparam int          SAT_AMP3  = 191;
    localparam int          DESC_MID  = 6;
    localparam int          DESC_FIN  = 0;
`else
    localparam logic [19:0] SAT_INC   = 20'hFFFFF;
    localparam int          SAT_AMP3  = 383;
    localparam int          DESC_MID  = 262;
    localparam int          DESC_FIN  = 1018;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_entry(input logic [1:0] addr, input logic [15:0] len, input logic [19:0] inc);
        bus.i_wr      = 1'b1;
        bus.i_wr_addr = addr;
        bus.i_wr_len  = len;
        bus.i_wr_inc  = inc;
        step();
        bus.i_wr      = 1'b0;
    endtask

    task automatic do_sync();
        bus.i_sync = 1'b1;
        step();
        bus.i_sync = 1'b0;
    endtask

    task automatic run_proc(input int n);
        bus.i_process = 1'b1;
        repeat (n) step();
        bus.i_process = 1'b0;
    endtask

    task automatic check_out(input string tag, input int one, input int two);
        check({tag, "_one"}, 32'(bus.o_amp_one), 32'(one));
        check({tag, "_two"}, 32'(bus.o_amp_two), 32'(two));
    endtask

    initial begin
        bus.i_sync = 1'b0;      bus.i_process = 1'b0;
        bus.i_start_amp = '0;   bus.i_amp_porch = '0;
        bus.i_wr = 1'b0;        bus.i_wr_addr = '0;
        bus.i_wr_len = '0;      bus.i_wr_inc = '0;

        repeat (3) step();
        check_out("reset", 0, 0);
        check("reset_done", 32'(bus.o_done), 0);
        check("reset_seg", 32'(bus.o_seg), 0);
        rst_n = 1'b1;
        step();

        // single ramp: 100 + 4 * 1.0, remaining segments skipped
        wr_entry(2'd0, 16'd4, 20'h02000);
        wr_entry(2'd1, 16'd0, 20'h02000);
        wr_entry(2'd2, 16'd0, 20'h02000);
        wr_entry(2'd3, 16'd0, 20'h02000);
        bus.i_start_amp = 11'd100;
        do_sync();
        run_proc(4);
        check("ramp_latency", 32'(bus.o_amp_one), 103);
        check("ramp_busy", 32'(bus.o_done), 0);
        step();
        check("ramp_one", 32'(bus.o_amp_one), 104);
        repeat (5) step();
        check_out("ramp_final", 104, 128);
        check("ramp_done", 32'(bus.o_done), 1);
        check("ramp_seg", 32'(bus.o_seg), 3);

        // stage-one overflow into stage two
        wr_entry(2'd0, 16'd10, 20'h02000);
        bus.i_start_amp = 11'd1020;
        do_sync();
        run_proc(5);
        check_out("ovf_1024", 1023, 128);
        run_proc(5);
        check_out("ovf_1029", 1023, 133);
        step();
        check_out("ovf_1030", 1023, 134);
        repeat (5) step();
        check("ovf_done", 32'(bus.o_done), 1);

        // large increment, pause, saturation
        wr_entry(2'd0, 16'hFFFF, SAT_INC);
        bus.i_start_amp = 11'd0;
        do_sync();
        run_proc(3);
        step();
        check("sat_step3", 32'(bus.o_amp_one), 32'(SAT_AMP3));
        repeat (5) step();
        check("pause_hold", 32'(bus.o_amp_one), 32'(SAT_AMP3));
        check("pause_seg", 32'(bus.o_seg), 0);
        run_proc(40);
        step();
        check_out("sat_clamp", 1023, 1023);
        repeat (5) step();
        check_out("sat_pause", 1023, 1023);
        check("sat_seg", 32'(bus.o_seg), 0);
        check("sat_busy", 32'(bus.o_done), 0);

        // sync coinciding with process: restart wins, no step
        bus.i_sync = 1'b1;
        bus.i_process = 1'b1;
        step();
        bus.i_sync = 1'b0;
        bus.i_process = 1'b0;
        step();
        check("sync_wins", 32'(bus.o_amp_one), 0);

        // porch floor, then an inc rewrite mid-scan is shadowed until the next sync
        wr_entry(2'd0, 16'd20, 20'h02000);
        bus.i_amp_porch = 10'd200;
        bus.i_start_amp = 11'd50;
        do_sync();
        run_proc(5);
        step();
        check_out("porch", 200, 200);
        wr_entry(2'd0, 16'd20, 20'h04000);
        run_proc(15);
        repeat (6) step();
        bus.i_amp_porch = 10'd0;
        step();
        check_out("shadow_old", 70, 128);
        check("shadow_done", 32'(bus.o_done), 1);
        do_sync();
        run_proc(20);
        repeat (6) step();
        check("shadow_new", 32'(bus.o_amp_one), 90);

        // descending increment (-2.0 when signed, 126.0 when unsigned)
        wr_entry(2'd0, 16'd8, 20'hFC000);
        bus.i_start_amp = 11'd10;
        do_sync();
        run_proc(3);
        check("desc_mid", 32'(bus.o_amp_one), 32'(DESC_MID));
        run_proc(5);
        repeat (6) step();
        check_out("desc_final", DESC_FIN, 128);
`ifdef VRC_SIGNED_INC_EN
        bus.i_amp_porch = 10'd5;
        step();
        check("desc_porch", 32'(bus.o_amp_one), 5);
        bus.i_amp_porch = 10'd0;
`endif

        // asynchronous reset in the middle of a scan
        do_sync();
        bus.i_process = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0);
        check("async_rst_done", 32'(bus.o_done), 0);
        check("async_rst_seg", 32'(bus.o_seg), 0);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        bus.i_process = 1'b0;
        check("idle_amp", 32'(bus.o_amp_one), 10);
        check("idle_done", 32'(bus.o_done), 0);
        check("idle_seg", 32'(bus.o_seg), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
